// File: rtl/nasti_mux_pkg.sv
// Shared types, constants and the round-robin pick helper for the NASTI
// arbitrating multiplexer.
package nasti_mux_pkg;

  // Number of ID bits prepended to carry the source port index.
  localparam int PORT_BITS = 3;
  // Physical port count of every port array.
  localparam int MAX_PORTS = 8;
  // Width of the outstanding-transaction counters (MAX_OUT up to 255).
  localparam int CNT_W     = 8;

  typedef enum logic {IDLE, DATA} wstate_t;

  // First requesting port at or after ptr, wrapping. Returns ptr when nothing
  // requests, so callers must qualify the result with the request vector.
  function automatic logic [PORT_BITS-1:0] rr_pick(input logic [MAX_PORTS-1:0] req,
                                                   input logic [PORT_BITS-1:0] ptr);
    logic [PORT_BITS-1:0] idx;
    logic                 found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int i = 0; i < MAX_PORTS; i++) begin
      idx = ptr + PORT_BITS'(i);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/nasti_mux_if.sv
// NASTI (AXI4) channel bundle carrying an array of ports. The master modport
// drives requests and accepts responses; the slave modport is its mirror.
interface nasti_channel #(
  parameter int N_PORT     = nasti_mux_pkg::MAX_PORTS,
  parameter int ID_WIDTH   = 1,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int USER_WIDTH = 1
);
  localparam int STRB_WIDTH = (DATA_WIDTH + 7) / 8;

  logic [N_PORT-1:0][ID_WIDTH-1:0]   aw_id;
  logic [N_PORT-1:0][ADDR_WIDTH-1:0] aw_addr;
  logic [N_PORT-1:0][7:0]            aw_len;
  logic [N_PORT-1:0][2:0]            aw_size;
  logic [N_PORT-1:0][1:0]            aw_burst;
  logic [N_PORT-1:0][2:0]            aw_prot;
  logic [N_PORT-1:0][USER_WIDTH-1:0] aw_user;
  logic [N_PORT-1:0]                 aw_valid;
  logic [N_PORT-1:0]                 aw_ready;

  logic [N_PORT-1:0][DATA_WIDTH-1:0] w_data;
  logic [N_PORT-1:0][STRB_WIDTH-1:0] w_strb;
  logic [N_PORT-1:0]                 w_last;
  logic [N_PORT-1:0][USER_WIDTH-1:0] w_user;
  logic [N_PORT-1:0]                 w_valid;
  logic [N_PORT-1:0]                 w_ready;

  logic [N_PORT-1:0][ID_WIDTH-1:0]   b_id;
  logic [N_PORT-1:0][1:0]            b_resp;
  logic [N_PORT-1:0][USER_WIDTH-1:0] b_user;
  logic [N_PORT-1:0]                 b_valid;
  logic [N_PORT-1:0]                 b_ready;

  logic [N_PORT-1:0][ID_WIDTH-1:0]   ar_id;
  logic [N_PORT-1:0][ADDR_WIDTH-1:0] ar_addr;
  logic [N_PORT-1:0][7:0]            ar_len;
  logic [N_PORT-1:0][2:0]            ar_size;
  logic [N_PORT-1:0][1:0]            ar_burst;
  logic [N_PORT-1:0][2:0]            ar_prot;
  logic [N_PORT-1:0][USER_WIDTH-1:0] ar_user;
  logic [N_PORT-1:0]                 ar_valid;
  logic [N_PORT-1:0]                 ar_ready;

  logic [N_PORT-1:0][ID_WIDTH-1:0]   r_id;
  logic [N_PORT-1:0][DATA_WIDTH-1:0] r_data;
  logic [N_PORT-1:0][1:0]            r_resp;
  logic [N_PORT-1:0]                 r_last;
  logic [N_PORT-1:0][USER_WIDTH-1:0] r_user;
  logic [N_PORT-1:0]                 r_valid;
  logic [N_PORT-1:0]                 r_ready;

  modport master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_prot, aw_user, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_prot, ar_user, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );

  modport slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_prot, aw_user, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_prot, ar_user, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );

endinterface

// File: rtl/nasti_mux_rr.sv
// Round-robin arbiter with a frozen grant: once a request has been presented
// downstream the grant holds until its handshake, so valid is never withdrawn.
module nasti_mux_rr
  import nasti_mux_pkg::*;
#(
  parameter int PORTS = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [MAX_PORTS-1:0] req,
  input  logic                 issue,
  input  logic                 ack,
  output logic [PORT_BITS-1:0] grant,
  output logic                 gnt_vld
);

  localparam logic [MAX_PORTS-1:0] PORT_MASK = MAX_PORTS'((1 << PORTS) - 1);
  localparam logic [PORT_BITS-1:0] LAST_PORT = PORT_BITS'(PORTS - 1);

  logic [MAX_PORTS-1:0] req_m;
  logic [PORT_BITS-1:0] ptr;
  logic [PORT_BITS-1:0] held;
  logic                 frozen;

  // Select the held grant while frozen, otherwise a fresh round-robin pick.
  always_comb begin
    req_m = req & PORT_MASK;
    if (frozen) begin
      grant   = held;
      gnt_vld = req_m[held];
    end else begin
      grant   = rr_pick(req_m, ptr);
      gnt_vld = |req_m;
    end
  end

  // Advance the pointer past the winner on handshake; freeze on an unaccepted issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr    <= '0;
      held   <= '0;
      frozen <= 1'b0;
    end else if (ack) begin
      ptr    <= (grant == LAST_PORT) ? '0 : grant + 1'b1;
      frozen <= 1'b0;
    end else if (issue) begin
      held   <= grant;
      frozen <= 1'b1;
    end
  end

endmodule

// File: rtl/nasti_mux.sv
// Arbitrating multiplexer: merges up to 8 NASTI masters onto one port,
// prepends the source index to the ID and routes B/R back by those bits.
module nasti_mux
  import nasti_mux_pkg::*;
#(
  parameter int PORTS      = 2,
  parameter int ID_WIDTH   = 1,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int USER_WIDTH = 1,
  parameter int LITE_MODE  = 0,
  parameter int MAX_OUT    = 4
) (
  input  logic         clk,
  input  logic         rst,
  nasti_channel.slave  master,
  nasti_channel.master slave
);

  localparam logic [CNT_W-1:0] CAP    = CNT_W'(MAX_OUT);
  localparam int               STRB_W = (DATA_WIDTH + 7) / 8;

  logic                 live;
  logic [PORT_BITS-1:0] ar_gnt, aw_gnt;
  logic                 ar_vld, aw_vld;
  logic                 ar_en, aw_en;
  logic                 ar_issue, aw_issue;
  logic                 ar_hs, aw_hs;
  logic                 w_hs, w_done, b_hs, r_hs, r_done;
  logic [PORT_BITS-1:0] b_port, r_port;
  wstate_t              state, state_nxt;
  logic [PORT_BITS-1:0] locked, locked_nxt;
  logic [CNT_W-1:0]     rd_cnt, wr_cnt;

  // Saturating up/down step; simultaneous increment and decrement cancel.
  function automatic logic [CNT_W-1:0] cnt_step(input logic [CNT_W-1:0] cnt,
                                                input logic inc, input logic dec);
    cnt_step = cnt;
    if (inc && !dec && cnt != '1)
      cnt_step = cnt + 1'b1;
    else if (dec && !inc && cnt != '0)
      cnt_step = cnt - 1'b1;
  endfunction

  // Every valid/ready is forced low while reset is held.
  assign live     = !rst;
  assign ar_en    = live && (rd_cnt < CAP);
  assign ar_issue = ar_vld && ar_en;
  assign ar_hs    = ar_issue && slave.ar_ready[0];
  assign aw_en    = live && (state == IDLE) && (wr_cnt < CAP);
  assign aw_issue = aw_vld && aw_en;
  assign aw_hs    = aw_issue && slave.aw_ready[0];
  assign w_hs     = slave.w_valid[0] && slave.w_ready[0];
  assign w_done   = w_hs && slave.w_last[0];
  assign b_port   = slave.b_id[0][ID_WIDTH +: PORT_BITS];
  assign r_port   = slave.r_id[0][ID_WIDTH +: PORT_BITS];
  assign b_hs     = slave.b_valid[0] && slave.b_ready[0];
  assign r_hs     = slave.r_valid[0] && slave.r_ready[0];
  assign r_done   = r_hs && slave.r_last[0];

  nasti_mux_rr #(.PORTS(PORTS)) u_ar_rr (
    .clk    (clk),
    .rst    (rst),
    .req    (master.ar_valid),
    .issue  (ar_issue),
    .ack    (ar_hs),
    .grant  (ar_gnt),
    .gnt_vld(ar_vld)
  );

  nasti_mux_rr #(.PORTS(PORTS)) u_aw_rr (
    .clk    (clk),
    .rst    (rst),
    .req    (master.aw_valid),
    .issue  (aw_issue),
    .ack    (aw_hs),
    .grant  (aw_gnt),
    .gnt_vld(aw_vld)
  );

  // AR: forward the granted request with its port index prepended to the ID.
  always_comb begin
    slave.ar_valid  = '0;
    slave.ar_id     = '0;
    slave.ar_addr   = '0;
    slave.ar_len    = '0;
    slave.ar_size   = '0;
    slave.ar_burst  = '0;
    slave.ar_prot   = '0;
    slave.ar_user   = '0;
    master.ar_ready = '0;
    slave.ar_valid[0] = ar_issue;
    slave.ar_id[0]    = {ar_gnt, master.ar_id[ar_gnt]};
    slave.ar_addr[0]  = ADDR_WIDTH'(master.ar_addr[ar_gnt]);
    slave.ar_len[0]   = master.ar_len[ar_gnt];
    slave.ar_size[0]  = master.ar_size[ar_gnt];
    slave.ar_burst[0] = master.ar_burst[ar_gnt];
    slave.ar_prot[0]  = master.ar_prot[ar_gnt];
    slave.ar_user[0]  = USER_WIDTH'(master.ar_user[ar_gnt]);
    if (ar_en && int'(ar_gnt) < PORTS)
      master.ar_ready[ar_gnt] = slave.ar_ready[0];
  end

  // AW: same as AR, but only offered while the write FSM is idle.
  always_comb begin
    slave.aw_valid  = '0;
    slave.aw_id     = '0;
    slave.aw_addr   = '0;
    slave.aw_len    = '0;
    slave.aw_size   = '0;
    slave.aw_burst  = '0;
    slave.aw_prot   = '0;
    slave.aw_user   = '0;
    master.aw_ready = '0;
    slave.aw_valid[0] = aw_issue;
    slave.aw_id[0]    = {aw_gnt, master.aw_id[aw_gnt]};
    slave.aw_addr[0]  = ADDR_WIDTH'(master.aw_addr[aw_gnt]);
    slave.aw_len[0]   = master.aw_len[aw_gnt];
    slave.aw_size[0]  = master.aw_size[aw_gnt];
    slave.aw_burst[0] = master.aw_burst[aw_gnt];
    slave.aw_prot[0]  = master.aw_prot[aw_gnt];
    slave.aw_user[0]  = USER_WIDTH'(master.aw_user[aw_gnt]);
    if (aw_en && int'(aw_gnt) < PORTS)
      master.aw_ready[aw_gnt] = slave.aw_ready[0];
  end

  // W: only the locked port is connected, and only during DATA.
  always_comb begin
    slave.w_valid  = '0;
    slave.w_data   = '0;
    slave.w_strb   = '0;
    slave.w_last   = '0;
    slave.w_user   = '0;
    master.w_ready = '0;
    slave.w_data[0] = DATA_WIDTH'(master.w_data[locked]);
    slave.w_strb[0] = STRB_W'(master.w_strb[locked]);
    slave.w_last[0] = (LITE_MODE != 0) ? 1'b1 : master.w_last[locked];
    slave.w_user[0] = USER_WIDTH'(master.w_user[locked]);
    if (live && state == DATA) begin
      slave.w_valid[0]      = master.w_valid[locked];
      master.w_ready[locked] = slave.w_ready[0];
    end
  end

  // Write FSM state and locked port register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      locked <= '0;
    end else begin
      state  <= state_nxt;
      locked <= locked_nxt;
    end
  end

  // Write FSM next state: lock the AW winner, release on the final W beat.
  always_comb begin
    state_nxt  = state;
    locked_nxt = locked;
    case (state)
      IDLE: begin
        if (aw_hs) begin
          state_nxt  = DATA;
          locked_nxt = aw_gnt;
        end
      end
      DATA: begin
        if (w_done)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // B: route by the prepended port bits; beats for absent ports are sunk.
  always_comb begin
    master.b_valid = '0;
    master.b_id    = '0;
    master.b_resp  = '0;
    master.b_user  = '0;
    slave.b_ready  = '0;
    for (int i = 0; i < MAX_PORTS; i++) begin
      master.b_id[i]   = slave.b_id[0][ID_WIDTH-1:0];
      master.b_resp[i] = slave.b_resp[0];
      master.b_user[i] = USER_WIDTH'(slave.b_user[0]);
    end
    if (live) begin
      if (int'(b_port) < PORTS) begin
        master.b_valid[b_port] = slave.b_valid[0];
        slave.b_ready[0]       = master.b_ready[b_port];
      end else begin
        slave.b_ready[0] = 1'b1;
      end
    end
  end

  // R: route by the prepended port bits; beats for absent ports are sunk.
  always_comb begin
    master.r_valid = '0;
    master.r_id    = '0;
    master.r_data  = '0;
    master.r_resp  = '0;
    master.r_last  = '0;
    master.r_user  = '0;
    slave.r_ready  = '0;
    for (int i = 0; i < MAX_PORTS; i++) begin
      master.r_id[i]   = slave.r_id[0][ID_WIDTH-1:0];
      master.r_data[i] = DATA_WIDTH'(slave.r_data[0]);
      master.r_resp[i] = slave.r_resp[0];
      master.r_last[i] = slave.r_last[0];
      master.r_user[i] = USER_WIDTH'(slave.r_user[0]);
    end
    if (live) begin
      if (int'(r_port) < PORTS) begin
        master.r_valid[r_port] = slave.r_valid[0];
        slave.r_ready[0]       = master.r_ready[r_port];
      end else begin
        slave.r_ready[0] = 1'b1;
      end
    end
  end

  // Outstanding-transaction counters: requests in, completions out.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else begin
      rd_cnt <= cnt_step(rd_cnt, ar_hs, r_done);
      wr_cnt <= cnt_step(wr_cnt, aw_hs, b_hs);
    end
  end

endmodule

// File: doc/nasti_mux.md
# nasti_mux

Arbitrating multiplexer that merges up to 8 NASTI (AXI4) master ports onto one NASTI master port, directly upstream of `nasti_demux`; the pair forms one crossbar slice. AW/W and AR are arbitrated round-robin, and the source port index is prepended to the ID. Returning B/R beats are routed back by the top three ID bits, with the prepended bits stripped. Per-direction outstanding-transaction counters cap in-flight traffic.

## Interface
- `PORTS`, 2: active input ports (1–8). Ports ≥ PORTS are ignored: ready = 0, valid out = 0.
- `ID_WIDTH`, 1: ID width on the input side. Output ID width is ID_WIDTH+3.
- `ADDR_WIDTH`, 8: address width.
- `DATA_WIDTH`, 8: data width.
- `USER_WIDTH`, 1: user field width.
- `LITE_MODE`, 0: when 1, every write is a single beat and `w_last` is ignored.
- `MAX_OUT`, 4: maximum in-flight reads, and separately writes (1–255).
- `clk`, in, 1: clock; all state changes on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `master`, `nasti_channel.slave`, 8-port arrays, ID_WIDTH: upstream masters.
- `slave`, `nasti_channel.master`, port 0 only, ID_WIDTH+3: merged output feeding `nasti_demux`.

## Operation
- **Reset:** state IDLE; both RR pointers = 0; `wr_cnt` = `rd_cnt` = 0.
  - All valid outputs low, all ready outputs low, for the whole reset cycle.
- **AR arbitration:** grant = first requesting `ar_valid` port at or after the pointer, wrapping.
  - The grant is frozen once issued until the `slave.ar` handshake, so an AXI valid is never withdrawn.
  - On handshake: pointer ← grant+1 mod PORTS; `rd_cnt` increments.
  - `slave.ar_id` = {grant[2:0], `master.ar_id`}.
  - `master.ar_ready[g]` = `slave.ar_ready` && `rd_cnt` < MAX_OUT; all other ports get 0.
- **Write FSM:**
  - IDLE: AW arbitrated exactly as AR, gated by `wr_cnt` < MAX_OUT. On the `slave.aw` handshake: locked ← grant, state → DATA, `wr_cnt` increments.
  - DATA: only port `locked` drives `slave.w_*`; `master.w_ready` = 0 for every other port; AW is stalled (`aw_ready` = 0 on all ports).
  - On a W handshake with `w_last`, or any W handshake when LITE_MODE=1: state → IDLE.
  - W beats presented before their AW handshake stall with `w_ready` = 0.
- **B/R routing:** p = `slave.{b,r}_id[ID_WIDTH+2:ID_WIDTH]`.
  - `master.{b,r}_valid[p]` = `slave` valid; `slave.{b,r}_ready` = `master.{b,r}_ready[p]`; ID bits [ID_WIDTH-1:0] passed through.
  - If p ≥ PORTS: ready = 1 and the beat is discarded.
- **Counters:** `rd_cnt` decrements on an R handshake with `r_last`; `wr_cnt` decrements on a B handshake.
  - Increment and decrement in the same cycle leave the count unchanged.
  - Counters saturate and never wrap.

## Timing
- Zero-latency path: every payload/valid/ready is combinational from arbiter state; no added pipeline cycle.
- Registered state: pointers, frozen grants, write FSM, locked port, counters.
- Write FSM transitions IDLE→DATA→IDLE on the handshake edges; AW for the next burst can be accepted the cycle after `w_last` completes.
- A 1-beat burst whose AW and W arrive together takes 2 cycles: AW in cycle n, W in n+1.
- At `rd_cnt` == MAX_OUT the next AR stalls. If an `r_last` handshake occurs in cycle n, `ar_ready` may rise in n+1 (not combinationally in n).
- A `rst` assertion mid-burst aborts it: the FSM returns to IDLE and counters clear. Upstream/downstream must be reset together.

## Structure
- Shared package `nasti_mux_pkg`:
  - `typedef enum logic {IDLE, DATA} wstate_t`.
  - Constant `PORT_BITS = 3`.
  - Function `rr_pick(req[7:0], ptr[2:0])` returning the index.
- One sub-module, `nasti_mux_rr`: RR pointer plus frozen grant, sync active-high reset, instantiated once for AW and once for AR.

## Test plan
- **AR round-robin:** ports 0, 1, 2 hold `ar_valid` with `ar_ready` = 1 → grants 0, 1, 2, 0 on consecutive cycles; `slave.ar_id` upper bits 0, 1, 2, 0.
- **Write lock:** port 1 issues AW len=3 while port 0 issues AW in the same cycle → port 0 AW accepted; its 4 W beats pass; port 1 sees `aw_ready` = 0 until the cycle after port 0's `w_last`.
- **Response routing:** `slave.r_id` = {3'd2, 1'b1}, 2 beats → only `master.r_valid[2]`, with `r_id` = 1; backpressure on `r_ready[2]` propagates to `slave.r_ready`.
- **Outstanding cap:** MAX_OUT=2, issue 3 ARs with no R → the third stalls; one `r_last` handshake → third AR accepted next cycle; `rd_cnt` = 2.
- **Invalid port / simultaneous events:** B with port bits 7 and PORTS=2 → `slave.b_ready` = 1, no master `b_valid`. AR handshake and `r_last` in the same cycle → counter unchanged.
- **Reset mid-burst:** `rst` pulsed after 2 of 4 W beats → all valids/readies low during reset; FSM IDLE; counters 0; the next AW is accepted normally.
